serial_byte_adder: RTL
======================

// Module: serial_byte_adder
// PURPOSE
//  Multi-byte adder front end. Accepts two wide operands one byte per beat, LSB
//  byte first, and feeds each byte pair to the existing FA_8_bit adder. The
//  adder's carry-out is registered and chained into the next beat. Emits the sum
//  stream byte-by-byte with per-byte carry and a final signed-overflow flag.
//  Sits between the operand source (upstream valid/ready) and the result consumer.
// PARAMETERS
//  NUM_BYTES  4  bytes per operand (operand width = 8*NUM_BYTES); legal range 2..16
//  CNT_W      4  byte-index counter width; must satisfy 2**CNT_W >= NUM_BYTES
// PORTS
//  clk        in   1  single clock, all state updates on rising edge
//  rst        in   1  synchronous, active-high reset
//  flush      in   1  synchronous abort of the operand in progress
//  in_valid   in   1  upstream byte pair valid
//  in_ready   out  1  block can accept a byte pair this cycle
//  in_a       in   8  operand A byte
//  in_b       in   8  operand B byte
//  in_cin     in   1  carry-in; sampled only on byte 0 of an operand
//  out_valid  out  1  result byte valid
//  out_ready  in   1  downstream accepts result byte
//  out_sum    out  8  sum byte
//  out_cout   out  1  carry-out of this byte (co_bit_8 of the adder)
//  out_last   out  1  this is byte NUM_BYTES-1 of the operand
//  out_ovf    out  1  signed overflow of the full operand; valid only with out_last, else 0
//  busy       out  1  operand in progress (byte_idx != 0) or out_valid high
// BEHAVIOUR
//  Reset: out_valid, out_sum, out_cout, out_last, out_ovf, busy, byte_idx and
//   carry_q all 0; state IDLE; in_ready = 0 while rst is high.
//  Handshake:
//   - in_ready = !rst && !flush && (!out_valid || out_ready).
//   - Accept when in_valid && in_ready. Output is held stable while
//     out_valid && !out_ready.
//  Latency: 1 cycle. The byte accepted at edge N appears on out_* after edge N.
//   Full throughput of 1 byte/cycle with out_ready held high.
//  Arithmetic: cin_eff = (byte_idx==0) ? in_cin : carry_q. The existing adder forms
//   {cout, sum} = in_a + in_b + cin_eff. carry_q <= cout on accept.
//  Overflow (last byte only): ovf = (in_a[7]==in_b[7]) && (sum[7]!=in_a[7]).
//  FSM (2 states):
//   - IDLE (byte_idx==0): accept -> RUN. If NUM_BYTES==1 were allowed it would stay
//     IDLE, but that setting is illegal.
//   - RUN: accept of byte NUM_BYTES-1 -> IDLE, with byte_idx wrapping to 0 and
//     carry_q cleared. Any other accept increments byte_idx.
//   - No accept: hold state.
//  Boundaries:
//   - flush: state IDLE, byte_idx 0, carry_q 0, out_valid 0 (pending result byte
//     discarded). Flush wins over a simultaneous in_valid; that byte is not accepted.
//   - Simultaneous output pop and new accept in the same cycle: allowed, no bubble.
//   - rst mid-operand: same as reset values. The next accepted byte is byte 0 and
//     uses in_cin.
//   - in_cin on bytes 1..NUM_BYTES-1 is ignored.
//   - Carry never leaks across operands.
// STRUCTURE
//  - Shared defs include adder_defs.vh: BYTE_W=8, state encodings ST_IDLE/ST_RUN.
//  - One sub-module: the existing FA_8_bit instance for the byte add. Control,
//    counter and output register live in this module.
// TESTING (NUM_BYTES=4)
//  1. A=0x000000FF, B=0x00000001, cin=0 -> out_sum 00,01,00,00; out_cout 1,0,0,0;
//     out_last on 4th byte; out_ovf 0.
//  2. A=0xFFFFFFFF, B=0x00000000, cin=1 -> out_sum 00,00,00,00; out_cout 1 on every
//     byte; final cout 1; out_ovf 0.
//  3. A=0x7FFFFFFF, B=0x00000001, cin=0 -> out_sum 00,00,00,80; out_ovf 1 on last
//     byte; out_cout 0 on last byte.
//  4. Test 1 with out_ready low 3 cycles after the first result -> in_ready low,
//     out_sum=0x00 held stable, no byte lost or duplicated; final stream same as test 1.
//  5. flush after byte 1 of A=0x000000FF/B=0x01 (carry_q=1), then A=1, B=1, cin=0 ->
//     first result byte 0x02 with out_cout 0.
//  6. rst for 1 cycle after byte 2 accepted -> all outputs 0 next cycle; next byte
//     A=0xFF, B=0x00, cin=1 yields sum 0x00, cout 1, out_last 0.

Source files
------------

// File: rtl/serial_byte_adder_pkg.sv
// Shared definitions for the serial multi-byte adder: byte width, control states,
// the registered result record and the signed-overflow rule.
package serial_byte_adder_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [BYTE_W-1:0] sum;
    logic              cout;
    logic              last;
    logic              ovf;
  } res_t;

  // Two's-complement overflow: operands agree in sign but the result does not.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/serial_byte_adder_if.sv
// Byte-stream bus of the serial adder: operand input channel and result output
// channel, each with its own valid/ready handshake.
interface serial_byte_adder_if;
  import serial_byte_adder_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [BYTE_W-1:0] in_a;
  logic [BYTE_W-1:0] in_b;
  logic              in_cin;

  logic              out_valid;
  logic              out_ready;
  logic [BYTE_W-1:0] out_sum;
  logic              out_cout;
  logic              out_last;
  logic              out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_last, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_last, out_ovf
  );

endinterface

// File: rtl/serial_byte_adder_fa.sv
// FA_8_bit: combinational 8-bit ripple-carry adder with carry-in, exposing the
// final carry as co_bit_8.
module FA_8_bit
  import serial_byte_adder_pkg::*;
(
  input  logic [BYTE_W-1:0] a_i,
  input  logic [BYTE_W-1:0] b_i,
  input  logic              ci_i,
  output logic [BYTE_W-1:0] sum_o,
  output logic              co_bit_8_o
);

  logic [BYTE_W:0] carry;

  always_comb begin
    carry    = '0;
    sum_o    = '0;
    carry[0] = ci_i;
    for (int unsigned i = 0; i < BYTE_W; i++) begin
      sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i+1]   = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
    co_bit_8_o = carry[BYTE_W];
  end

endmodule

// File: rtl/serial_byte_adder.sv
// Multi-byte adder front end: takes operands one byte pair per beat (LSB first),
// chains the byte carry between beats and registers each result byte.
module serial_byte_adder
  import serial_byte_adder_pkg::*;
#(
  parameter int unsigned NUM_BYTES = 4,
  parameter int unsigned CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  serial_byte_adder_if.slave   bus,
  output logic                 busy_o
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic              carry_q, carry_d;
  res_t              res_q, res_d;
  logic              ovalid_q, ovalid_d;

  logic              in_ready;
  logic              accept;
  logic              is_last;
  logic              cin_eff;
  logic [BYTE_W-1:0] fa_sum;
  logic              fa_cout;

  FA_8_bit u_fa (
    .a_i        (bus.in_a),
    .b_i        (bus.in_b),
    .ci_i       (cin_eff),
    .sum_o      (fa_sum),
    .co_bit_8_o (fa_cout)
  );

  // External carry only enters on byte 0; later bytes use the chained carry.
  always_comb begin
    in_ready = !rst && !flush_i && (!ovalid_q || bus.out_ready);
    accept   = bus.in_valid && in_ready;
    is_last  = (idx_q == LAST_IDX);
    cin_eff  = (idx_q == '0) ? bus.in_cin : carry_q;
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    res_d    = res_q;
    ovalid_d = ovalid_q;

    if (ovalid_q && bus.out_ready) begin
      ovalid_d = 1'b0;
    end

    if (flush_i) begin
      state_d  = ST_IDLE;
      idx_d    = '0;
      carry_d  = 1'b0;
      ovalid_d = 1'b0;
    end else if (accept) begin
      ovalid_d   = 1'b1;
      res_d.sum  = fa_sum;
      res_d.cout = fa_cout;
      res_d.last = is_last;
      res_d.ovf  = is_last && signed_ovf(bus.in_a[BYTE_W-1], bus.in_b[BYTE_W-1],
                                         fa_sum[BYTE_W-1]);
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_RUN;
          idx_d   = idx_q + CNT_W'(1);
          carry_d = fa_cout;
        end
        ST_RUN: begin
          if (is_last) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            carry_d = 1'b0;
          end else begin
            idx_d   = idx_q + CNT_W'(1);
            carry_d = fa_cout;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      res_q    <= '0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      res_q    <= res_d;
      ovalid_q <= ovalid_d;
    end
  end

  always_comb begin
    bus.in_ready  = in_ready;
    bus.out_valid = ovalid_q;
    bus.out_sum   = res_q.sum;
    bus.out_cout  = res_q.cout;
    bus.out_last  = res_q.last;
    bus.out_ovf   = res_q.ovf;
    busy_o        = (idx_q != '0) || ovalid_q;
  end

endmodule
